// File: rtl/csr_flag_unit.sv
// Flag register for ALU S/Z/C/O, branch-condition evaluation and an interrupt shadow stack.
// 1-cycle latency on csr_q; no backpressure, illegal push/pop only raises sticky err.

package csr_flag_pkg;
  typedef struct packed {
    logic s;
    logic z;
    logic c;
    logic o;
  } csr_t;
endpackage

module csr_flag_unit
  import csr_flag_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_we,
  input  csr_t             csr_in,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  input  logic [2:0]       cond,
  output csr_t             csr_q,
  output logic             cond_true,
  output logic [CNT_W-1:0] depth,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_NE     = 3'b010;
  localparam logic [2:0] COND_CS     = 3'b011;
  localparam logic [2:0] COND_CC     = 3'b100;
  localparam logic [2:0] COND_MI     = 3'b101;
  localparam logic [2:0] COND_VS     = 3'b110;
  localparam logic [2:0] COND_LT     = 3'b111;

  csr_t             stack_mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;
  logic             illegal;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] depth_m1;

  assign full  = (depth == CNT_MAX);
  assign empty = (depth == '0);

  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  // Simultaneous push/pop, push on full and pop on empty are all illegal.
  assign illegal = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);

  assign depth_m1 = depth - CNT_ONE;
  assign wr_idx   = depth[IDX_W-1:0];
  assign rd_idx   = depth_m1[IDX_W-1:0];

  // Restored flags from a pop take priority over a concurrent ALU load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_q <= '0;
    end else if (pop_ok) begin
      csr_q <= stack_mem[rd_idx];
    end else if (flag_we) begin
      csr_q <= csr_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
    end else if (push_ok) begin
      depth <= depth + CNT_ONE;
    end else if (pop_ok) begin
      depth <= depth_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_mem[wr_idx] <= csr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (illegal) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_ALWAYS: cond_true = 1'b1;
      COND_EQ:     cond_true = csr_q.z;
      COND_NE:     cond_true = ~csr_q.z;
      COND_CS:     cond_true = csr_q.c;
      COND_CC:     cond_true = ~csr_q.c;
      COND_MI:     cond_true = csr_q.s;
      COND_VS:     cond_true = csr_q.o;
      COND_LT:     cond_true = csr_q.s ^ csr_q.o;
      default:     cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_csr_flag_unit.sv
// Directed bench for csr_flag_unit with a reference model feeding a scoreboard queue.

module tb_csr_flag_unit;
  import csr_flag_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             flag_we;
  csr_t             csr_in;
  logic             push;
  logic             pop;
  logic             err_clr;
  logic [2:0]       cond;
  csr_t             csr_q;
  logic             cond_true;
  logic [CNT_W-1:0] depth;
  logic             full;
  logic             empty;
  logic             err;

  csr_flag_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .csr_in(csr_in),
    .push(push), .pop(pop), .err_clr(err_clr), .cond(cond),
    .csr_q(csr_q), .cond_true(cond_true), .depth(depth),
    .full(full), .empty(empty), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    csr_t  csr;
    int    dep;
    bit    err;
  } exp_t;

  exp_t sb[$];
  csr_t m_stack[$];
  csr_t m_csr;
  bit   m_err;

  int vectors = 0;
  int miscompares = 0;

  function automatic csr_t mk(bit s, bit z, bit c, bit o);
    csr_t f;
    f.s = s; f.z = z; f.c = c; f.o = o;
    return f;
  endfunction

  function automatic bit cond_ref(csr_t f, logic [2:0] c);
    case (c)
      3'd0: return 1'b1;
      3'd1: return f.z;
      3'd2: return !f.z;
      3'd3: return f.c;
      3'd4: return !f.c;
      3'd5: return f.s;
      3'd6: return f.o;
      default: return f.s != f.o;
    endcase
  endfunction

  task automatic cmp(string tag, logic [7:0] obs, logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(string tag, csr_t e_csr, int e_dep, bit e_err);
    cmp({tag, ".csr_q"}, 8'(csr_q), 8'(e_csr));
    cmp({tag, ".depth"}, 8'(depth), 8'(e_dep));
    cmp({tag, ".err"}, 8'(err), 8'(e_err));
    cmp({tag, ".full"}, 8'(full), 8'(e_dep == DEPTH));
    cmp({tag, ".empty"}, 8'(empty), 8'(e_dep == 0));
  endtask

  // Drive one cycle of stimulus, predict its outcome, then check after the edge.
  task automatic step(string tag, bit fwe, csr_t din, bit psh, bit pp, bit clr);
    exp_t e;
    csr_t old;
    bit   push_ok, pop_ok, bad;
    @(negedge clk);
    flag_we = fwe; csr_in = din; push = psh; pop = pp; err_clr = clr;
    old     = m_csr;
    push_ok = psh && !pp && (m_stack.size() < DEPTH);
    pop_ok  = pp && !psh && (m_stack.size() > 0);
    bad     = (psh || pp) && !push_ok && !pop_ok;
    if (pop_ok) m_csr = m_stack.pop_back();
    else if (fwe) m_csr = din;
    if (push_ok) m_stack.push_back(old);
    if (bad) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    e.tag = tag; e.csr = m_csr; e.dep = m_stack.size(); e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    flag_we = 0; push = 0; pop = 0; err_clr = 0;
    e = sb.pop_front();
    check_state(e.tag, e.csr, e.dep, e.err);
  endtask

  task automatic check_conds(string tag);
    for (int c = 0; c < 8; c++) begin
      cond = 3'(c);
      #1;
      cmp($sformatf("%s.cond%0d", tag, c), 8'(cond_true), 8'(cond_ref(m_csr, 3'(c))));
    end
  endtask

  initial begin
    rst_n = 0; flag_we = 0; csr_in = '0; push = 0; pop = 0; err_clr = 0; cond = 3'd0;
    m_csr = '0; m_err = 0;
    #12;
    check_state("reset", mk(0,0,0,0), 0, 0);
    rst_n = 1;

    // Load flags and evaluate branch conditions on them.
    step("load_sc", 1, mk(1,0,1,0), 0, 0, 0);
    cmp("load_sc.lit_csr", 8'(csr_q), 8'h0A);
    check_conds("sc");

    // Push with concurrent load, then restore.
    step("load_z", 1, mk(0,1,0,0), 0, 0, 0);
    step("push_we", 1, mk(0,0,1,0), 1, 0, 0);
    cmp("push_we.lit_csr", 8'(csr_q), 8'h02);
    check_conds("c");
    step("pop_z", 0, '0, 0, 1, 0);
    cmp("pop_z.lit_csr", 8'(csr_q), 8'h04);

    // Fill, overflow, then drain in LIFO order.
    for (int i = 0; i < DEPTH; i++) begin
      step($sformatf("fill_ld%0d", i), 1, 4'(i + 3), 0, 0, 0);
      step($sformatf("fill_push%0d", i), 0, '0, 1, 0, 0);
    end
    step("overflow", 1, mk(1,1,1,1), 1, 0, 0);
    check_conds("ssss");
    step("err_clr1", 0, '0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step($sformatf("drain%0d", i), 0, '0, 0, 1, 0);

    // Underflow with concurrent load; err set wins over err_clr.
    step("underflow", 1, mk(0,0,0,1), 0, 1, 1);
    cmp("underflow.lit_csr", 8'(csr_q), 8'h01);
    check_conds("o");
    step("err_clr2", 0, '0, 0, 0, 1);

    // Simultaneous push/pop at depth 2, then pop beating flag_we.
    step("d2_push0", 1, mk(1,0,0,0), 1, 0, 0);
    step("d2_push1", 1, mk(0,1,1,0), 1, 0, 0);
    step("push_pop", 1, mk(1,1,0,0), 1, 1, 0);
    step("pop_we", 1, mk(1,1,1,1), 0, 1, 0);
    check_conds("popwe");

    // Async reset mid-cycle with depth 3 and err set.
    step("d3_push", 0, '0, 1, 0, 0);
    step("d3_push2", 1, mk(0,1,0,1), 1, 0, 0);
    step("d3_bad", 0, '0, 1, 1, 0);
    #2;
    rst_n = 0;
    m_csr = '0; m_err = 0; m_stack.delete();
    #1;
    check_state("async_rst", mk(0,0,0,0), 0, 0);
    #10;
    rst_n = 1;
    step("post_rst_pop", 0, '0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
